draw_mux_sync: RTL and testbench

//  Parametrised screen-source selector for the snake draw path: picks one of N_SRC

---
 rtl/draw_mux_sync_if.sv | 43 ++++
 rtl/draw_mux_sync.sv | 144 ++++++++++++++
 tb/tb_draw_mux_sync.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_mux_sync_if.sv
// Bundle of per-source VGA timing/RGB streams, the source request, and the
// registered output stream of the draw-path screen selector.
interface draw_mux_sync_if #(
    parameter int N_SRC = 6,
    parameter int HC_W  = 11,
    parameter int RGB_B = 12
);
    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [SEL_W-1:0]       sel_i;
    logic [N_SRC*HC_W-1:0]  src_hcount;
    logic [N_SRC*HC_W-1:0]  src_vcount;
    logic [N_SRC-1:0]       src_hblnk;
    logic [N_SRC-1:0]       src_vblnk;
    logic [N_SRC-1:0]       src_hsync;
    logic [N_SRC-1:0]       src_vsync;
    logic [N_SRC*RGB_B-1:0] src_rgb;

    logic [HC_W-1:0]        hcount_o;
    logic [HC_W-1:0]        vcount_o;
    logic                   hblnk_o;
    logic                   vblnk_o;
    logic                   hsync_o;
    logic                   vsync_o;
    logic [RGB_B-1:0]       rgb_o;
    logic [SEL_W-1:0]       cur_sel_o;
    logic                   busy_o;
    logic                   switched_o;

    modport master (
        output sel_i, src_hcount, src_vcount, src_hblnk, src_vblnk,
               src_hsync, src_vsync, src_rgb,
        input  hcount_o, vcount_o, hblnk_o, vblnk_o, hsync_o, vsync_o,
               rgb_o, cur_sel_o, busy_o, switched_o
    );

    modport slave (
        input  sel_i, src_hcount, src_vcount, src_hblnk, src_vblnk,
               src_hsync, src_vsync, src_rgb,
        output hcount_o, vcount_o, hblnk_o, vblnk_o, hsync_o, vsync_o,
               rgb_o, cur_sel_o, busy_o, switched_o
    );
endinterface

// File: rtl/draw_mux_sync.sv
// Screen-source selector: switches between delay-aligned VGA streams only at a
// frame boundary, optionally inserting black frames after each switch.
module draw_mux_sync #(
    parameter int N_SRC        = 6,
    parameter int HC_W         = 11,
    parameter int RGB_B        = 12,
    parameter int BLANK_FRAMES = 0,
    parameter int RST_SEL      = 0
) (
    input  logic          clk,
    input  logic          rst,
    draw_mux_sync_if.slave bus
);
    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int BC_W  = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

    typedef enum logic [1:0] {SHOW, WAIT, BLANK} state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] cur_sel, cur_sel_nxt;
    logic [SEL_W-1:0] pend, pend_nxt;
    logic [BC_W-1:0]  blank_cnt, blank_cnt_nxt;
    logic             switch_now;
    logic             busy_p1, switched_p1;

    logic [HC_W-1:0]  s_hc, s_vc;
    logic             s_hb, s_vb, s_hs, s_vs;
    logic [RGB_B-1:0] s_rgb;
    logic             frame_start, sel_valid;

    logic [HC_W-1:0]  hcount_p1, vcount_p1;
    logic             hblnk_p1, vblnk_p1, hsync_p1, vsync_p1;
    logic [RGB_B-1:0] rgb_p1;

    function automatic logic [RGB_B-1:0] rgb_gate(input logic [RGB_B-1:0] px,
                                                  input logic blank);
        return blank ? '0 : px;
    endfunction

    assign s_hc  = bus.src_hcount[int'(cur_sel)*HC_W +: HC_W];
    assign s_vc  = bus.src_vcount[int'(cur_sel)*HC_W +: HC_W];
    assign s_hb  = bus.src_hblnk[cur_sel];
    assign s_vb  = bus.src_vblnk[cur_sel];
    assign s_hs  = bus.src_hsync[cur_sel];
    assign s_vs  = bus.src_vsync[cur_sel];
    assign s_rgb = bus.src_rgb[int'(cur_sel)*RGB_B +: RGB_B];

    assign frame_start = (s_hc == '0) && (s_vc == '0);
    assign sel_valid   = (int'(bus.sel_i) < N_SRC);

    always_comb begin
        state_nxt     = state;
        cur_sel_nxt   = cur_sel;
        pend_nxt      = pend;
        blank_cnt_nxt = blank_cnt;
        switch_now    = 1'b0;
        case (state)
            SHOW: begin
                if (sel_valid && bus.sel_i != cur_sel) begin
                    pend_nxt  = bus.sel_i;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A cancel back to the shown source beats a coincident frame boundary.
                if (sel_valid && bus.sel_i == cur_sel) begin
                    state_nxt = SHOW;
                end else begin
                    if (sel_valid)
                        pend_nxt = bus.sel_i;
                    if (frame_start) begin
                        switch_now  = 1'b1;
                        cur_sel_nxt = pend_nxt;
                        if (BLANK_FRAMES > 0) begin
                            state_nxt     = BLANK;
                            blank_cnt_nxt = BC_W'(BLANK_FRAMES);
                        end else begin
                            state_nxt = SHOW;
                        end
                    end
                end
            end
            BLANK: begin
                if (frame_start) begin
                    blank_cnt_nxt = (blank_cnt != '0) ? blank_cnt - 1'b1 : '0;
                    if (blank_cnt <= BC_W'(1))
                        state_nxt = SHOW;
                end
            end
            default: state_nxt = SHOW;
        endcase
    end

    // Control stage: FSM state, selection and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SHOW;
            cur_sel     <= SEL_W'(RST_SEL);
            pend        <= SEL_W'(RST_SEL);
            blank_cnt   <= '0;
            busy_p1     <= 1'b0;
            switched_p1 <= 1'b0;
        end else begin
            state       <= state_nxt;
            cur_sel     <= cur_sel_nxt;
            pend        <= pend_nxt;
            blank_cnt   <= blank_cnt_nxt;
            busy_p1     <= (state_nxt != SHOW);
            switched_p1 <= switch_now;
        end
    end

    // Output stage: one-cycle register of the currently selected stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_p1 <= '0;
            vcount_p1 <= '0;
            hblnk_p1  <= 1'b0;
            vblnk_p1  <= 1'b0;
            hsync_p1  <= 1'b0;
            vsync_p1  <= 1'b0;
            rgb_p1    <= '0;
        end else begin
            hcount_p1 <= s_hc;
            vcount_p1 <= s_vc;
            hblnk_p1  <= s_hb;
            vblnk_p1  <= s_vb;
            hsync_p1  <= s_hs;
            vsync_p1  <= s_vs;
            rgb_p1    <= rgb_gate(s_rgb, s_hb | s_vb | (state == BLANK));
        end
    end

    assign bus.hcount_o   = hcount_p1;
    assign bus.vcount_o   = vcount_p1;
    assign bus.hblnk_o    = hblnk_p1;
    assign bus.vblnk_o    = vblnk_p1;
    assign bus.hsync_o    = hsync_p1;
    assign bus.vsync_o    = vsync_p1;
    assign bus.rgb_o      = rgb_p1;
    assign bus.cur_sel_o  = cur_sel;
    assign bus.busy_o     = busy_p1;
    assign bus.switched_o = switched_p1;
endmodule

// File: tb/tb_draw_mux_sync.sv
// Directed bench for draw_mux_sync: one instance without and one with black
// frames after a switch, both fed the same miniature 8x4 frame timing.
module tb_draw_mux_sync;
    localparam int N  = 6;
    localparam int HW = 11;
    localparam int RB = 12;
    localparam int HT = 8;
    localparam int VT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    draw_mux_sync_if #(.N_SRC(N), .HC_W(HW), .RGB_B(RB)) ifa ();
    draw_mux_sync_if #(.N_SRC(N), .HC_W(HW), .RGB_B(RB)) ifb ();

    draw_mux_sync #(.N_SRC(N), .HC_W(HW), .RGB_B(RB), .BLANK_FRAMES(0), .RST_SEL(0))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    draw_mux_sync #(.N_SRC(N), .HC_W(HW), .RGB_B(RB), .BLANK_FRAMES(2), .RST_SEL(0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int tests = 0;
    int fails = 0;
    int hc = 0, vc = 0, prev_hc = 0, prev_vc = 0;
    logic [RB-1:0] base [N] = '{12'hABC, 12'h111, 12'h222, 12'h333, 12'h444, 12'h555};

    task automatic drive();
        logic [N*HW-1:0] th, tv;
        logic [N-1:0]    thb, tvb, ths, tvs;
        logic [N*RB-1:0] trgb;
        for (int k = 0; k < N; k++) begin
            th[k*HW +: HW]   = HW'(hc);
            tv[k*HW +: HW]   = HW'(vc);
            thb[k]           = (hc >= 6 && hc < HT);
            tvb[k]           = (vc >= 3 && vc < VT);
            ths[k]           = (hc == 7);
            tvs[k]           = (vc == 3);
            trgb[k*RB +: RB] = base[k] + RB'(hc);
        end
        ifa.src_hcount = th;  ifb.src_hcount = th;
        ifa.src_vcount = tv;  ifb.src_vcount = tv;
        ifa.src_hblnk  = thb; ifb.src_hblnk  = thb;
        ifa.src_vblnk  = tvb; ifb.src_vblnk  = tvb;
        ifa.src_hsync  = ths; ifb.src_hsync  = ths;
        ifa.src_vsync  = tvs; ifb.src_vsync  = tvs;
        ifa.src_rgb    = trgb; ifb.src_rgb   = trgb;
    endtask

    task automatic set_pos(input int h, input int v);
        hc = h; vc = v;
        drive();
    endtask

    // Outputs seen after tick() reflect the inputs at (prev_hc, prev_vc).
    task automatic tick();
        @(posedge clk); #1;
        prev_hc = hc; prev_vc = vc;
        if (hc >= HT - 1) begin
            hc = 0;
            vc = (vc >= VT - 1) ? 0 : vc + 1;
        end else begin
            hc = hc + 1;
        end
        drive();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifa.sel_i = 3'd0; ifb.sel_i = 3'd0;
        set_pos(0, 1);
        #12;
        tests++; if (ifa.rgb_o !== 12'h000) begin fails++; $display("FAIL reset_rgb_a got %h exp 000", ifa.rgb_o); end
        tests++; if (ifb.rgb_o !== 12'h000) begin fails++; $display("FAIL reset_rgb_b got %h exp 000", ifb.rgb_o); end
        tests++; if (ifa.cur_sel_o !== 3'd0 || ifa.busy_o !== 1'b0 || ifa.switched_o !== 1'b0)
            begin fails++; $display("FAIL reset_ctrl_a got sel=%0d busy=%b sw=%b exp 0/0/0", ifa.cur_sel_o, ifa.busy_o, ifa.switched_o); end
        tests++; if (ifa.hcount_o !== 11'd0 || ifa.vcount_o !== 11'd0 || ifa.vsync_o !== 1'b0)
            begin fails++; $display("FAIL reset_timing_a got h=%0d v=%0d vs=%b exp 0/0/0", ifa.hcount_o, ifa.vcount_o, ifa.vsync_o); end
        @(negedge clk); rst = 1'b1;
        tick();
        tests++; if (ifa.rgb_o !== 12'hABC) begin fails++; $display("FAIL first_pixel got %h exp ABC", ifa.rgb_o); end
        tests++; if (ifa.hcount_o !== 11'd0 || ifa.vcount_o !== 11'd1)
            begin fails++; $display("FAIL first_timing got h=%0d v=%0d exp 0/1", ifa.hcount_o, ifa.vcount_o); end
        tests++; if (ifa.cur_sel_o !== 3'd0 || ifa.busy_o !== 1'b0)
            begin fails++; $display("FAIL first_ctrl got sel=%0d busy=%b exp 0/0", ifa.cur_sel_o, ifa.busy_o); end
    endtask

    task automatic test_switch();
        set_pos(100, 50);
        ifa.sel_i = 3'd5;
        tick();
        tests++; if (ifa.rgb_o !== 12'hB20 || ifa.cur_sel_o !== 3'd0 || ifa.busy_o !== 1'b1)
            begin fails++; $display("FAIL switch_wait got rgb=%h sel=%0d busy=%b exp B20/0/1", ifa.rgb_o, ifa.cur_sel_o, ifa.busy_o); end
        tick();
        tests++; if (ifa.switched_o !== 1'b1 || ifa.cur_sel_o !== 3'd5 || ifa.busy_o !== 1'b0)
            begin fails++; $display("FAIL switch_edge got sw=%b sel=%0d busy=%b exp 1/5/0", ifa.switched_o, ifa.cur_sel_o, ifa.busy_o); end
        tests++; if (ifa.rgb_o !== 12'hABC) begin fails++; $display("FAIL switch_last_old_px got %h exp ABC", ifa.rgb_o); end
        tick();
        tests++; if (ifa.rgb_o !== 12'h556 || ifa.switched_o !== 1'b0 || ifa.hcount_o !== 11'd1)
            begin fails++; $display("FAIL switch_new_px got rgb=%h sw=%b h=%0d exp 556/0/1", ifa.rgb_o, ifa.switched_o, ifa.hcount_o); end
    endtask

    task automatic test_last_wins();
        int npulse = 0;
        int ph = -1, pv = -1;
        ifa.sel_i = 3'd4;
        tick();
        ifa.sel_i = 3'd3;
        tick();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifa.switched_o === 1'b1) begin npulse++; ph = prev_hc; pv = prev_vc; end
        end
        tests++; if (npulse != 1 || ifa.cur_sel_o !== 3'd3)
            begin fails++; $display("FAIL last_wins got pulses=%0d sel=%0d exp 1/3", npulse, ifa.cur_sel_o); end
        tests++; if (ph != 0 || pv != 0)
            begin fails++; $display("FAIL last_wins_boundary got h=%0d v=%0d exp 0/0", ph, pv); end
        ifa.sel_i = 3'd0;
        tick();
        tests++; if (ifa.busy_o !== 1'b1) begin fails++; $display("FAIL cancel_pending got busy=%b exp 1", ifa.busy_o); end
        ifa.sel_i = 3'd3;
        tick();
        tests++; if (ifa.busy_o !== 1'b0 || ifa.cur_sel_o !== 3'd3)
            begin fails++; $display("FAIL cancel got busy=%b sel=%0d exp 0/3", ifa.busy_o, ifa.cur_sel_o); end
        ifa.sel_i = 3'd0;
        tick();
        set_pos(0, 0);
        ifa.sel_i = 3'd3;
        tick();
        tests++; if (ifa.switched_o !== 1'b0 || ifa.cur_sel_o !== 3'd3 || ifa.busy_o !== 1'b0)
            begin fails++; $display("FAIL cancel_at_boundary got sw=%b sel=%0d busy=%b exp 0/3/0", ifa.switched_o, ifa.cur_sel_o, ifa.busy_o); end
        npulse = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifa.switched_o === 1'b1) npulse++;
        end
        tests++; if (npulse != 0) begin fails++; $display("FAIL cancel_no_switch got pulses=%0d exp 0", npulse); end
    endtask

    task automatic test_invalid();
        int nbusy = 0;
        bit seen = 0;
        ifa.sel_i = 3'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ifa.busy_o !== 1'b0) nbusy++;
        end
        tests++; if (nbusy != 0 || ifa.cur_sel_o !== 3'd3)
            begin fails++; $display("FAIL invalid_sel got busy_cycles=%0d sel=%0d exp 0/3", nbusy, ifa.cur_sel_o); end
        ifa.sel_i = 3'd0;
        tick();
        ifa.sel_i = 3'd7;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifa.switched_o === 1'b1) begin seen = 1; break; end
        end
        tests++; if (!seen || ifa.cur_sel_o !== 3'd0)
            begin fails++; $display("FAIL invalid_keeps_pend got seen=%0d sel=%0d exp 1/0", seen, ifa.cur_sel_o); end
        set_pos(6, 1);
        tick();
        tests++; if (ifa.rgb_o !== 12'h000 || ifa.hblnk_o !== 1'b1)
            begin fails++; $display("FAIL hblank_black got rgb=%h hb=%b exp 000/1", ifa.rgb_o, ifa.hblnk_o); end
        set_pos(2, 3);
        tick();
        tests++; if (ifa.rgb_o !== 12'h000 || ifa.vblnk_o !== 1'b1 || ifa.vsync_o !== 1'b1)
            begin fails++; $display("FAIL vblank_black got rgb=%h vb=%b vs=%b exp 000/1/1", ifa.rgb_o, ifa.vblnk_o, ifa.vsync_o); end
        set_pos(5, 2);
        tick();
        tests++; if (ifa.rgb_o !== 12'hAC1) begin fails++; $display("FAIL active_px got %h exp AC1", ifa.rgb_o); end
    endtask

    task automatic test_blank();
        bit seen = 0;
        int nz = 0, hs = 0;
        logic busy63 = 1'b0;
        ifb.sel_i = 3'd1;
        set_pos(3, 1);
        tick();
        tests++; if (ifb.busy_o !== 1'b1) begin fails++; $display("FAIL blank_wait got busy=%b exp 1", ifb.busy_o); end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifb.switched_o === 1'b1) begin seen = 1; break; end
        end
        tests++; if (!seen || ifb.cur_sel_o !== 3'd1 || ifb.rgb_o !== 12'hABC)
            begin fails++; $display("FAIL blank_switch got seen=%0d sel=%0d rgb=%h exp 1/1/ABC", seen, ifb.cur_sel_o, ifb.rgb_o); end
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (ifb.rgb_o !== 12'h000) nz++;
            if (ifb.hsync_o === 1'b1) hs++;
            if (k == 63) busy63 = ifb.busy_o;
        end
        tests++; if (nz != 0) begin fails++; $display("FAIL blank_black got nonzero_px=%0d exp 0", nz); end
        tests++; if (hs != 8) begin fails++; $display("FAIL blank_hsync got pulses=%0d exp 8", hs); end
        tests++; if (busy63 !== 1'b1 || ifb.busy_o !== 1'b0)
            begin fails++; $display("FAIL blank_busy got last=%b after=%b exp 1/0", busy63, ifb.busy_o); end
        tick();
        tests++; if (ifb.rgb_o !== 12'h112 || ifb.cur_sel_o !== 3'd1)
            begin fails++; $display("FAIL blank_third_frame got rgb=%h sel=%0d exp 112/1", ifb.rgb_o, ifb.cur_sel_o); end
    endtask

    task automatic test_reset_mid();
        int npulse = 0;
        bit seen = 0;
        logic [RB-1:0] exp_rgb;
        ifb.sel_i = 3'd2;
        tick();
        tests++; if (ifb.busy_o !== 1'b1) begin fails++; $display("FAIL rstwait_pre got busy=%b exp 1", ifb.busy_o); end
        #2; rst = 1'b0; #1;
        tests++; if (ifb.busy_o !== 1'b0 || ifb.cur_sel_o !== 3'd0 || ifb.rgb_o !== 12'h000)
            begin fails++; $display("FAIL rstwait_async got busy=%b sel=%0d rgb=%h exp 0/0/000", ifb.busy_o, ifb.cur_sel_o, ifb.rgb_o); end
        ifb.sel_i = 3'd0; ifa.sel_i = 3'd0;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifb.switched_o === 1'b1) npulse++;
        end
        tests++; if (npulse != 0 || ifb.busy_o !== 1'b0)
            begin fails++; $display("FAIL rstwait_after got pulses=%0d busy=%b exp 0/0", npulse, ifb.busy_o); end
        ifb.sel_i = 3'd2;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifb.switched_o === 1'b1) begin seen = 1; break; end
        end
        tick();
        tests++; if (!seen || ifb.busy_o !== 1'b1 || ifb.rgb_o !== 12'h000)
            begin fails++; $display("FAIL rstblank_pre got seen=%0d busy=%b rgb=%h exp 1/1/000", seen, ifb.busy_o, ifb.rgb_o); end
        #2; rst = 1'b0; #1;
        tests++; if (ifb.busy_o !== 1'b0 || ifb.cur_sel_o !== 3'd0 || ifb.hsync_o !== 1'b0)
            begin fails++; $display("FAIL rstblank_async got busy=%b sel=%0d hs=%b exp 0/0/0", ifb.busy_o, ifb.cur_sel_o, ifb.hsync_o); end
        ifb.sel_i = 3'd0;
        @(negedge clk); rst = 1'b1;
        npulse = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifb.switched_o === 1'b1 || ifb.busy_o !== 1'b0) npulse++;
        end
        tests++; if (npulse != 0) begin fails++; $display("FAIL rstblank_after got bad_cycles=%0d exp 0", npulse); end
        exp_rgb = (prev_hc < 6 && prev_vc < 3) ? 12'hABC + RB'(prev_hc) : 12'h000;
        tests++; if (ifb.rgb_o !== exp_rgb || ifb.cur_sel_o !== 3'd0)
            begin fails++; $display("FAIL rstblank_px got rgb=%h sel=%0d exp %h/0", ifb.rgb_o, ifb.cur_sel_o, exp_rgb); end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_last_wins();
        test_invalid();
        test_blank();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
